// File: rtl/adc_multi_capture_if.sv
// -----------------------------------------------------------------------------
// adc_multi_capture_if
// AXI4-Stream style sample bus carrying one converted ADC channel per beat.
//   tdata  : signed two's-complement sample, OUT_WIDTH bits
//   tvalid : beat valid (master -> slave)
//   tready : slave can accept (slave -> master)
//   tlast  : last channel of the frame
//   tuser  : channel index of the current beat
// -----------------------------------------------------------------------------
interface adc_multi_capture_if #(
  parameter int OUT_WIDTH = 16
) ();
  logic [OUT_WIDTH-1:0] tdata;
  logic                 tvalid;
  logic                 tready;
  logic                 tlast;
  logic [2:0]           tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser, output tready);
endinterface

// File: rtl/adc_multi_capture.sv
// -----------------------------------------------------------------------------
// adc_multi_capture
// Captures NUM_CH parallel ADC samples on (decimated) rising edges of an
// asynchronous sample clock, removes an optional offset and streams the frame
// out one channel per beat.
//   clk, rst_n    : system clock, synchronous active-low reset
//   clk_sample    : ADC sample clock, asynchronous to clk
//   data_in       : raw unsigned samples, channel k at [k*W +: W]
//   cfg_enable    : allow new captures
//   cfg_offset_en : subtract cfg_offset when set
//   cfg_offset    : unsigned offset
//   cfg_decim     : capture one frame every cfg_decim+1 sample events
//   m_axis        : output sample stream (master side)
//   eoc           : one-cycle pulse with the first beat of each frame
//   overflow      : sticky frame-dropped flag, cleared by clr_overflow
//   drop_count    : saturating dropped-frame counter, cleared by clr_overflow
// -----------------------------------------------------------------------------
module adc_multi_capture #(
  parameter int NUM_CH         = 4,
  parameter int ADC_DATA_WIDTH = 12,
  parameter int OUT_WIDTH      = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clk_sample,
  input  logic [NUM_CH*ADC_DATA_WIDTH-1:0] data_in,
  input  logic                             cfg_enable,
  input  logic                             cfg_offset_en,
  input  logic [ADC_DATA_WIDTH-1:0]        cfg_offset,
  input  logic [7:0]                       cfg_decim,
  adc_multi_capture_if.master              m_axis,
  output logic                             eoc,
  output logic                             overflow,
  input  logic                             clr_overflow,
  output logic [15:0]                      drop_count
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  // Zero-extended difference in ADC_DATA_WIDTH+1 bits is always representable,
  // so only sign extension to the output width is needed.
  function automatic logic signed [OUT_WIDTH-1:0] sub_offset(
    input logic [ADC_DATA_WIDTH-1:0] raw,
    input logic [ADC_DATA_WIDTH-1:0] off
  );
    logic signed [ADC_DATA_WIDTH:0] diff;
    logic signed [OUT_WIDTH-1:0]    ext;
    diff = $signed({1'b0, raw}) - $signed({1'b0, off});
    ext  = diff;
    return ext;
  endfunction

  state_t                           r_state;
  logic                             r_sync1, r_sync2, r_sync3;
  logic [7:0]                       r_decim_cnt;
  logic [NUM_CH*ADC_DATA_WIDTH-1:0] r_frame;
  logic signed [OUT_WIDTH-1:0]      r_tdata;
  logic                             r_tvalid;
  logic                             r_tlast;
  logic [2:0]                       r_tuser;
  logic                             r_eoc;
  logic                             r_overflow;
  logic [15:0]                      r_drop_cnt;

  logic [ADC_DATA_WIDTH-1:0] w_off;
  logic                      w_sample_evt;
  logic                      w_eligible;
  logic                      w_hs;
  logic                      w_last_hs;
  logic                      w_cap;
  logic                      w_drop;
  logic [2:0]                w_next_ch;
  logic [ADC_DATA_WIDTH-1:0] w_next_raw;

  assign w_off        = cfg_offset_en ? cfg_offset : '0;
  assign w_sample_evt = r_sync2 & ~r_sync3;
  assign w_eligible   = w_sample_evt && (r_decim_cnt == 8'd0) && cfg_enable;
  assign w_hs         = r_tvalid && m_axis.tready;
  assign w_last_hs    = w_hs && r_tlast;
  // A capture landing on the final handshake starts the next frame seamlessly.
  assign w_cap        = w_eligible && ((r_state == S_IDLE) || w_last_hs);
  assign w_drop       = w_eligible && (r_state == S_EMIT) && !w_last_hs;
  assign w_next_ch    = r_tuser + 3'd1;
  assign w_next_raw   = r_frame[w_next_ch*ADC_DATA_WIDTH +: ADC_DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync3     <= 1'b0;
      r_decim_cnt <= 8'd0;
      r_frame     <= '0;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_tuser     <= 3'd0;
      r_eoc       <= 1'b0;
      r_overflow  <= 1'b0;
      r_drop_cnt  <= 16'd0;
    end else begin
      r_sync1 <= clk_sample;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_eoc   <= 1'b0;

      // Decimation runs on every sample event, independent of cfg_enable.
      if (w_sample_evt) begin
        if (r_decim_cnt >= cfg_decim) r_decim_cnt <= 8'd0;
        else                          r_decim_cnt <= r_decim_cnt + 8'd1;
      end

      if (w_cap) begin
        r_state  <= S_EMIT;
        r_frame  <= data_in;
        r_tvalid <= 1'b1;
        r_tuser  <= 3'd0;
        r_tdata  <= sub_offset(data_in[ADC_DATA_WIDTH-1:0], w_off);
        r_tlast  <= (NUM_CH == 1);
        r_eoc    <= 1'b1;
      end else if ((r_state == S_EMIT) && w_hs) begin
        if (r_tlast) begin
          r_state  <= S_IDLE;
          r_tvalid <= 1'b0;
          r_tlast  <= 1'b0;
        end else begin
          r_tuser <= w_next_ch;
          r_tdata <= sub_offset(w_next_raw, w_off);
          r_tlast <= (w_next_ch == 3'(NUM_CH - 1));
        end
      end

      // A drop coinciding with a clear leaves exactly that one drop recorded.
      if (clr_overflow) begin
        r_overflow <= w_drop;
        r_drop_cnt <= w_drop ? 16'd1 : 16'd0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign m_axis.tdata  = r_tdata;
  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tlast  = r_tlast;
  assign m_axis.tuser  = r_tuser;
  assign eoc           = r_eoc;
  assign overflow      = r_overflow;
  assign drop_count    = r_drop_cnt;

endmodule

// File: doc/adc_multi_capture.md
ADC_MULTI_CAPTURE -- requirements
Module: adc_multi_capture

Interface
REQ-001 Parameter NUM_CH, default 4: number of parallel ADC channels, legal range 1..8.
REQ-002 Parameter ADC_DATA_WIDTH, default 12: raw ADC sample width.
REQ-003 Parameter OUT_WIDTH, default 16: output sample width; SHALL be >= ADC_DATA_WIDTH+1.
REQ-004 Port clk  in  1  system clock; all logic on rising edge.
REQ-005 Port rst_n  in  1  reset, synchronous, active-low.
REQ-006 Port clk_sample  in  1  ADC sample clock; asynchronous to clk.
REQ-007 Port data_in  in  NUM_CH*ADC_DATA_WIDTH  raw unsigned samples; channel k at bits [k*W +: W].
REQ-008 Port cfg_enable  in  1  capture enable.
REQ-009 Port cfg_offset_en  in  1  subtract cfg_offset when 1, else offset 0.
REQ-010 Port cfg_offset  in  ADC_DATA_WIDTH  unsigned offset.
REQ-011 Port cfg_decim  in  8  capture one frame every cfg_decim+1 sample events.
REQ-012 Port m_axis_tdata  out  OUT_WIDTH  signed two's-complement sample.
REQ-013 Port m_axis_tvalid  out  1; m_axis_tready  in  1; m_axis_tlast  out  1  last channel of frame.
REQ-014 Port m_axis_tuser  out  3  channel index of current beat.
REQ-015 Port eoc  out  1  one-cycle pulse per captured frame.
REQ-016 Port overflow  out  1  sticky frame-drop flag; clr_overflow  in  1  clears it.
REQ-017 Port drop_count  out  16  saturating count of dropped frames.

Function
REQ-018 clk_sample SHALL pass a 2-flop synchronizer; a sample event is a 0->1 transition on the synchronizer output, one clk cycle wide.
REQ-019 Decimation counter SHALL increment on every sample event (regardless of cfg_enable), reset to 0 after reaching >= cfg_decim; a capture is eligible only when counter == 0 at the event.
REQ-020 Capture: on an eligible event with cfg_enable=1 and FSM in IDLE, all NUM_CH channels of data_in SHALL be latched in that same clk cycle into a frame register.
REQ-021 Arithmetic: out_k = zero-extended data_k minus zero-extended offset, computed in ADC_DATA_WIDTH+1 bits signed, sign-extended to OUT_WIDTH; no saturation needed.
REQ-022 FSM states IDLE, EMIT; IDLE->EMIT on capture; EMIT presents channel 0..NUM_CH-1 in order, advancing on tvalid&&tready.
REQ-023 m_axis_tvalid SHALL assert the cycle after capture; tdata/tuser/tlast SHALL be stable while tvalid=1 and tready=0.
REQ-024 m_axis_tlast=1 only with tuser=NUM_CH-1; on its handshake FSM returns to IDLE.
REQ-025 eoc SHALL pulse high for one cycle, coincident with the first cycle tvalid is high for a frame.
REQ-026 Eligible event with cfg_enable=1 while in EMIT (not on the final handshake cycle): frame dropped, overflow set, drop_count += 1 saturating at 16'hFFFF.
REQ-027 Eligible event in the same cycle as the tlast handshake SHALL be captured as a new frame (no drop), EMIT continues from channel 0 with tvalid held high.
REQ-028 clr_overflow clears overflow and drop_count; a simultaneous drop SHALL win (overflow=1, drop_count=1).
REQ-029 cfg_enable deasserted mid-frame SHALL NOT abort the current frame; only new captures are blocked.
REQ-030 Config inputs are quasi-static and used directly without resynchronization.

Reset
REQ-031 While rst_n=0 at a clk edge: FSM IDLE, decim counter 0, synchronizer flops 0, frame register 0, m_axis_tvalid=0, tlast=0, tuser=0, tdata=0, eoc=0, overflow=0, drop_count=0.
REQ-032 Reset asserted mid-frame SHALL discard the frame; no beat emitted after reset release until a new capture.

Verification
REQ-033 NUM_CH=4, offset_en=0, decim=0, tready=1, data_in={12'h400,12'h300,12'h200,12'h100}, one clk_sample rising edge -> 4 beats tdata 0x0100,0x0200,0x0300,0x0400, tuser 0..3, tlast on beat 3, one eoc pulse.
REQ-034 offset_en=1, cfg_offset=12'h800, ch0=12'h000, ch1=12'hFFF -> ch0 tdata 16'hF800, ch1 tdata 16'h07FF.
REQ-035 tready=0 held for 20 cycles during frame while two eligible events occur -> tdata/tuser stable, overflow=1, drop_count=2; clr_overflow pulse -> both 0.
REQ-036 decim=2, 9 sample events -> exactly 3 frames (events 1,4,7), eoc pulses=3.
REQ-037 Sample event coincident with tlast handshake -> next frame starts without tvalid gap, drop_count unchanged; rst_n=0 mid-frame -> tvalid=0 next cycle, all outputs at reset values.
